// File: rtl/key_conditioner.sv
// key_conditioner: per-key synchroniser, debouncer and press/release strobe generator.
// Each key is normalised so that 1 = pressed. It then goes through a two-flop
// synchroniser and its own four-state debounce FSM. The FSM state of each key is
// held in g_key[i].state_q, where a checker can probe it hierarchically.
// Optional feature: define KEY_AUTOREPEAT_EN to add auto-repeat press strobes
// while a key stays pressed. The default build leaves the macro undefined.
// Handshake: none. All outputs are free-running registered levels and strobes,
// and nothing downstream can apply back-pressure.
module key_conditioner #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int ACTIVE_LOW      = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic             clk,
    input  logic             reset_p,
    input  logic [WIDTH-1:0] key_raw,
    output logic [WIDTH-1:0] key_sw_p,
    output logic [WIDTH-1:0] key_press_p,
    output logic [WIDTH-1:0] key_release_p
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_RELEASED     = 2'd0,
        ST_PRESS_WAIT   = 2'd1,
        ST_PRESSED      = 2'd2,
        ST_RELEASE_WAIT = 2'd3
    } key_state_e;

    // Parameters outside their legal range stop elaboration instead of building a broken counter.
    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("key_conditioner: DEBOUNCE_CYCLES must be >= 2 and repeat timings >= 1");
    end

    logic [WIDTH-1:0] norm;
    logic [WIDTH-1:0] sync1_q;
    logic [WIDTH-1:0] sync2_q;

    assign norm = (ACTIVE_LOW != 0) ? ~key_raw : key_raw;

    // Two-flop synchroniser for every key. These flops carry no functional reset
    // dependency, but they are cleared so that a held key counts as a new press after reset.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= norm;
            sync2_q <= sync1_q;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_key
        key_state_e    state_q, state_d;
        logic [CW-1:0] cnt_q, cnt_d;
        logic          sw_q, sw_d;
        logic          press_q, press_d;
        logic          rel_q, rel_d;
        logic          s2;

        assign s2 = sync2_q[g];

`ifdef KEY_AUTOREPEAT_EN
        localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
        localparam int RW      = (RPT_MAX > 1) ? $clog2(RPT_MAX) : 1;
        localparam logic [RW-1:0] RPT_DELAY_LAST  = RW'(REPEAT_DELAY - 1);
        localparam logic [RW-1:0] RPT_PERIOD_LAST = RW'(REPEAT_PERIOD - 1);

        logic [RW-1:0] rpt_cnt_q, rpt_cnt_d;
        logic          rpt_phase_q, rpt_phase_d;   // 0: waiting for the initial delay, 1: periodic
        logic          rpt_hit;

        assign rpt_hit = rpt_phase_q ? (rpt_cnt_q == RPT_PERIOD_LAST)
                                     : (rpt_cnt_q == RPT_DELAY_LAST);

        // Repeat counter state. It runs only in PRESSED and freezes while a release is being qualified.
        always_ff @(posedge clk or posedge reset_p) begin
            if (reset_p) begin
                rpt_cnt_q   <= '0;
                rpt_phase_q <= 1'b0;
            end else begin
                rpt_cnt_q   <= rpt_cnt_d;
                rpt_phase_q <= rpt_phase_d;
            end
        end
`endif

        // Debounce FSM state, counter and registered outputs.
        always_ff @(posedge clk or posedge reset_p) begin
            if (reset_p) begin
                state_q <= ST_RELEASED;
                cnt_q   <= '0;
                sw_q    <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                sw_q    <= sw_d;
                press_q <= press_d;
                rel_q   <= rel_d;
            end
        end

        // Next-state logic. A level is accepted only after the synchronised input
        // has held for DEBOUNCE_CYCLES+1 consecutive samples.
        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            press_d = 1'b0;
            rel_d   = 1'b0;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt_d   = rpt_cnt_q;
            rpt_phase_d = rpt_phase_q;
`endif
            case (state_q)
                ST_RELEASED: begin
`ifdef KEY_AUTOREPEAT_EN
                    rpt_cnt_d   = '0;
                    rpt_phase_d = 1'b0;
`endif
                    if (s2) begin
                        state_d = ST_PRESS_WAIT;
                        cnt_d   = '0;
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!s2) begin
                        state_d = ST_RELEASED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_PRESSED;
                        press_d = 1'b1;
`ifdef KEY_AUTOREPEAT_EN
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b0;
`endif
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                ST_PRESSED: begin
                    if (!s2) begin
                        state_d = ST_RELEASE_WAIT;
                        cnt_d   = '0;
                    end
`ifdef KEY_AUTOREPEAT_EN
                    else if (rpt_hit) begin
                        press_d     = 1'b1;
                        rpt_cnt_d   = '0;
                        rpt_phase_d = 1'b1;
                    end else begin
                        rpt_cnt_d = rpt_cnt_q + RW'(1);
                    end
`endif
                end
                ST_RELEASE_WAIT: begin
                    if (s2) begin
                        state_d = ST_PRESSED;
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ST_RELEASED;
                        rel_d   = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_d = ST_RELEASED;
                    cnt_d   = '0;
                end
            endcase
            sw_d = (state_d == ST_PRESSED) || (state_d == ST_RELEASE_WAIT);
        end

        assign key_sw_p[g]      = sw_q;
        assign key_press_p[g]   = press_q;
        assign key_release_p[g] = rel_q;
    end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed test-plan scenarios plus random key activity,
// every cycle compared against a run-length reference model of the debouncer.
module tb_key_conditioner;

    localparam int W  = 4;
    localparam int D  = 8;
    localparam int AL = 1;
    localparam int RD = 20;
    localparam int RP = 6;
`ifdef KEY_AUTOREPEAT_EN
    localparam bit AUTO_RPT = 1'b1;
`else
    localparam bit AUTO_RPT = 1'b0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_p;
    logic [W-1:0] key_raw;
    logic [W-1:0] key_sw_p;
    logic [W-1:0] key_press_p;
    logic [W-1:0] key_release_p;

    key_conditioner #(
        .WIDTH          (W),
        .DEBOUNCE_CYCLES(D),
        .ACTIVE_LOW     (AL),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk          (clk),
        .reset_p      (reset_p),
        .key_raw      (key_raw),
        .key_sw_p     (key_sw_p),
        .key_press_p  (key_press_p),
        .key_release_p(key_release_p)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [3*W-1:0] exp_q[$];

    int press_cnt[W];
    int rel_cnt[W];
    int last_rel_tick[W];
    int tick_no = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // A key's accepted level flips once the synchronised level has disagreed with
    // it for D+1 consecutive samples. Repeats are counted in undisturbed pressed cycles.
    logic [W-1:0] m_h1, m_h2, m_acc;
    int m_run[W];
    int m_t[W];

    task automatic model_reset();
        m_h1  = '0;
        m_h2  = '0;
        m_acc = '0;
        for (int i = 0; i < W; i++) begin
            m_run[i] = 0;
            m_t[i]   = 0;
        end
    endtask

    function automatic bit repeat_due(input int t);
        return AUTO_RPT && ((t == RD) || (t > RD && ((t - RD) % RP) == 0));
    endfunction

    task automatic model_edge();
        logic [W-1:0] n, pr, rl;
        pr = '0;
        rl = '0;
        if (reset_p) begin
            model_reset();
        end else begin
            n = (AL != 0) ? ~key_raw : key_raw;
            for (int i = 0; i < W; i++) begin
                if (m_h2[i] != m_acc[i]) begin
                    m_run[i]++;
                    if (m_run[i] == D + 1) begin
                        m_acc[i] = ~m_acc[i];
                        m_run[i] = 0;
                        m_t[i]   = 0;
                        if (m_acc[i]) pr[i] = 1'b1;
                        else          rl[i] = 1'b1;
                    end
                end else begin
                    if (m_acc[i] && m_run[i] == 0) begin
                        m_t[i]++;
                        if (repeat_due(m_t[i])) pr[i] = 1'b1;
                    end
                    m_run[i] = 0;
                end
            end
            m_h2 = m_h1;
            m_h1 = n;
        end
        exp_q.push_back({m_acc, pr, rl});
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        logic [3*W-1:0] e;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        tick_no++;
        e = exp_q.pop_front();
        check("key_sw_p", 32'(key_sw_p), 32'(e[3*W-1 -: W]));
        check("key_press_p", 32'(key_press_p), 32'(e[2*W-1 -: W]));
        check("key_release_p", 32'(key_release_p), 32'(e[W-1:0]));
        check("press_and_release", 32'(key_press_p & key_release_p), 32'd0);
        for (int i = 0; i < W; i++) begin
            if (key_press_p[i]) press_cnt[i]++;
            if (key_release_p[i]) begin
                rel_cnt[i]++;
                last_rel_tick[i] = tick_no;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int p0, r0, r1;
        for (int i = 0; i < W; i++) begin
            press_cnt[i]     = 0;
            rel_cnt[i]       = 0;
            last_rel_tick[i] = 0;
        end
        reset_p = 1'b1;
        key_raw = 4'hF;
        model_reset();
        #1;
        check("reset_sw", 32'(key_sw_p), 32'd0);
        check("reset_press", 32'(key_press_p), 32'd0);
        check("reset_release", 32'(key_release_p), 32'd0);
        ticks(2);
        reset_p = 1'b0;
        ticks(3);

        // Clean press on key 1. The strobe appears 10 edges after the first sampling edge.
        p0 = press_cnt[1];
        r0 = rel_cnt[1];
        key_raw = 4'b1101;
        ticks(10);
        check("press_early", 32'(key_press_p), 32'd0);
        tick();
        check("press_on_time", 32'(key_press_p), 32'b0010);
        check("sw_after_press", 32'(key_sw_p), 32'b0010);
        tick();
        check("press_one_cycle", 32'(key_press_p), 32'd0);
        ticks(49);
        check("press_count_hold", 32'(press_cnt[1] - p0), AUTO_RPT ? 32'd7 : 32'd1);

        // A 4-cycle release glitch while key 1 is held produces no release.
        key_raw[1] = 1'b1;
        ticks(4);
        key_raw[1] = 1'b0;
        ticks(15);
        check("glitch_no_release", 32'(rel_cnt[1] - r0), 32'd0);
        check("glitch_sw_held", 32'(key_sw_p[1]), 32'd1);

        // Release of key 1.
        key_raw = 4'hF;
        ticks(10);
        check("release_early", 32'(key_release_p), 32'd0);
        tick();
        check("release_on_time", 32'(key_release_p), 32'b0010);
        check("sw_after_release", 32'(key_sw_p), 32'd0);
        ticks(3);

        // Bounce on key 0: five 3-cycle low pulses, then high.
        p0 = press_cnt[0];
        for (int k = 0; k < 5; k++) begin
            key_raw[0] = 1'b0;
            ticks(3);
            key_raw[0] = 1'b1;
            ticks(3);
        end
        ticks(15);
        check("bounce_no_press", 32'(press_cnt[0] - p0), 32'd0);
        check("bounce_sw_low", 32'(key_sw_p[0]), 32'd0);

        // All keys pressed on the same edge, then keys 2 and 3 released 3 cycles apart.
        key_raw = 4'b0000;
        ticks(10);
        tick();
        check("simul_press", 32'(key_press_p), 32'hF);
        ticks(5);
        key_raw[2] = 1'b1;
        ticks(3);
        key_raw[3] = 1'b1;
        ticks(15);
        check("release_spacing", 32'(last_rel_tick[3] - last_rel_tick[2]), 32'd3);
        key_raw = 4'hF;
        ticks(15);

        // Reset during PRESS_WAIT on key 3 while the key stays held.
        key_raw[3] = 1'b0;
        ticks(7);
        r1 = rel_cnt[3];
        reset_p = 1'b1;
        #1;
        model_reset();
        check("midreset_sw", 32'(key_sw_p), 32'd0);
        check("midreset_press", 32'(key_press_p), 32'd0);
        ticks(2);
        reset_p = 1'b0;
        ticks(10);
        check("postreset_early", 32'(key_press_p), 32'd0);
        tick();
        check("postreset_press", 32'(key_press_p), 32'b1000);
        check("postreset_sw", 32'(key_sw_p), 32'b1000);
        check("postreset_no_release", 32'(rel_cnt[3] - r1), 32'd0);
        key_raw = 4'hF;
        ticks(15);

        // Random key activity with glitches of every length.
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(0, 5) == 0) begin
                int b;
                b = $urandom_range(0, W - 1);
                key_raw[b] = ~key_raw[b];
            end
            tick();
        end
        key_raw = 4'hF;
        ticks(20);
        check("final_sw", 32'(key_sw_p), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
